// File: rtl/bsg_gateway_pkg.sv
// Shared types for the gateway reset sequencer: FSM state encoding and
// relock-counter width.
package bsg_gateway_pkg;

  localparam int unsigned RelockW = 8;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_GAP_IO    = 3'd2,
    S_GAP_CORE  = 3'd3,
    S_DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/bsg_gateway_sync_2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_i domain.
module bsg_gateway_sync_2 (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/bsg_gateway_reset_seq.sv
// Gateway reset sequencer: waits for a stable PLL lock, then releases the
// microblaze, io and core resets in order, restarting on lock loss or request.
module bsg_gateway_reset_seq
  import bsg_gateway_pkg::*;
#(
  parameter int unsigned lock_stable_cycles_p = 1024,
  parameter int unsigned stage_gap_cycles_p   = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               locked_i,
  input  logic               sw_reset_i,
  output logic               mb_reset_o,
  output logic               io_reset_o,
  output logic               core_reset_o,
  output logic               ready_o,
  output logic [RelockW-1:0] relock_count_o
);

  localparam int unsigned MaxCyc = (lock_stable_cycles_p > stage_gap_cycles_p)
                                   ? lock_stable_cycles_p : stage_gap_cycles_p;
  localparam int unsigned CntW   = (MaxCyc < 2) ? 1 : $clog2(MaxCyc);

  if (lock_stable_cycles_p == 0) begin : g_bad_lock_param
    $error("lock_stable_cycles_p must be at least 1");
  end
  if (stage_gap_cycles_p == 0) begin : g_bad_gap_param
    $error("stage_gap_cycles_p must be at least 1");
  end

  localparam logic [CntW-1:0] LockLast = CntW'(lock_stable_cycles_p - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(stage_gap_cycles_p - 1);

  logic               w_locked_sync;
  logic               w_lost;
  state_e             r_state;
  state_e             w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic [CntW-1:0]    w_cnt_next;
  logic [RelockW-1:0] r_relock;
  logic [RelockW-1:0] w_relock_next;
  logic               r_mb_reset;
  logic               r_io_reset;
  logic               r_core_reset;
  logic               r_ready;
  logic               w_mb_reset_next;
  logic               w_io_reset_next;
  logic               w_core_reset_next;
  logic               w_ready_next;

  bsg_gateway_sync_2 u_lock_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (locked_i),
    .q_o     (w_locked_sync)
  );

  // State, stage counter, relock counter and output flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= S_WAIT_LOCK;
      r_cnt        <= '0;
      r_relock     <= '0;
      r_mb_reset   <= 1'b1;
      r_io_reset   <= 1'b1;
      r_core_reset <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_relock     <= w_relock_next;
      r_mb_reset   <= w_mb_reset_next;
      r_io_reset   <= w_io_reset_next;
      r_core_reset <= w_core_reset_next;
      r_ready      <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_relock_next = r_relock;
    w_lost        = (r_state != S_WAIT_LOCK) && !w_locked_sync;

    unique case (r_state)
      S_WAIT_LOCK: begin
        if (w_locked_sync) begin
          w_state_next = S_STABLE;
          w_cnt_next   = '0;
        end
      end
      S_STABLE: begin
        if (r_cnt == LockLast) begin
          w_state_next = S_GAP_IO;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      S_GAP_IO: begin
        if (r_cnt == GapLast) begin
          w_state_next = S_GAP_CORE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      S_GAP_CORE: begin
        if (r_cnt == GapLast) begin
          w_state_next = S_DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_WAIT_LOCK;
        w_cnt_next   = '0;
      end
    endcase

    // Lock loss and software request both restart; only lock loss is counted.
    if (w_lost || sw_reset_i) begin
      w_state_next = S_WAIT_LOCK;
      w_cnt_next   = '0;
    end
    if (w_lost && (r_relock != '1)) begin
      w_relock_next = r_relock + RelockW'(1);
    end

    w_mb_reset_next   = (w_state_next == S_WAIT_LOCK) || (w_state_next == S_STABLE);
    w_io_reset_next   = w_mb_reset_next || (w_state_next == S_GAP_IO);
    w_core_reset_next = (w_state_next != S_DONE);
    w_ready_next      = (w_state_next == S_DONE);
  end

  assign mb_reset_o     = r_mb_reset;
  assign io_reset_o     = r_io_reset;
  assign core_reset_o   = r_core_reset;
  assign ready_o        = r_ready;
  assign relock_count_o = r_relock;

endmodule

// File: tb/tb_bsg_gateway_reset_seq.sv
// Directed bench for the gateway reset sequencer with 8 stable / 4 gap cycles.
module tb_bsg_gateway_reset_seq;

  logic       clk;
  logic       reset_i;
  logic       locked_i;
  logic       sw_reset_i;
  logic       mb_reset_o;
  logic       io_reset_o;
  logic       core_reset_o;
  logic       ready_o;
  logic [7:0] relock_count_o;

  int n_checks;
  int n_err;

  bsg_gateway_reset_seq #(
    .lock_stable_cycles_p (8),
    .stage_gap_cycles_p   (4)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .locked_i       (locked_i),
    .sw_reset_i     (sw_reset_i),
    .mb_reset_o     (mb_reset_o),
    .io_reset_o     (io_reset_o),
    .core_reset_o   (core_reset_o),
    .ready_o        (ready_o),
    .relock_count_o (relock_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; locked_i = 1'b1; sw_reset_i = 1'b0;
    step(3);
    n_checks++; if (mb_reset_o !== 1'b1) begin n_err++; $display("FAIL reset_mb got=%b exp=1", mb_reset_o); end
    n_checks++; if (io_reset_o !== 1'b1) begin n_err++; $display("FAIL reset_io got=%b exp=1", io_reset_o); end
    n_checks++; if (core_reset_o !== 1'b1) begin n_err++; $display("FAIL reset_core got=%b exp=1", core_reset_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    n_checks++; if (relock_count_o !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", relock_count_o); end
  endtask

  // Cycle c is the value seen after edge c-1 (edge 0 = first edge with reset_i=0).
  task automatic test_powerup();
    int c;
    reset_i = 1'b0;
    for (int e = 0; e < 22; e++) begin
      step(1);
      c = e + 1;
      n_checks++; if (mb_reset_o !== logic'(c < 11)) begin n_err++; $display("FAIL powerup_mb cyc=%0d got=%b exp=%b", c, mb_reset_o, c < 11); end
      n_checks++; if (io_reset_o !== logic'(c < 15)) begin n_err++; $display("FAIL powerup_io cyc=%0d got=%b exp=%b", c, io_reset_o, c < 15); end
      n_checks++; if (core_reset_o !== logic'(c < 19)) begin n_err++; $display("FAIL powerup_core cyc=%0d got=%b exp=%b", c, core_reset_o, c < 19); end
      n_checks++; if (ready_o !== logic'(c >= 19)) begin n_err++; $display("FAIL powerup_ready cyc=%0d got=%b exp=%b", c, ready_o, c >= 19); end
    end
    n_checks++; if (relock_count_o !== 8'd0) begin n_err++; $display("FAIL powerup_count got=%0d exp=0", relock_count_o); end
  endtask

  // From DONE: software restart into STABLE, then a 3-cycle lock dropout.
  task automatic test_glitch_stable();
    sw_reset_i = 1'b1;
    step(1);
    sw_reset_i = 1'b0;
    n_checks++; if ({mb_reset_o, io_reset_o, core_reset_o, ready_o} !== 4'b1110) begin n_err++; $display("FAIL glitch_swreset outs got=%b exp=1110", {mb_reset_o, io_reset_o, core_reset_o, ready_o}); end
    n_checks++; if (relock_count_o !== 8'd0) begin n_err++; $display("FAIL glitch_swreset_count got=%0d exp=0", relock_count_o); end
    step(1);
    locked_i = 1'b0;
    step(3);
    locked_i = 1'b1;
    n_checks++; if (relock_count_o !== 8'd1) begin n_err++; $display("FAIL glitch_count got=%0d exp=1", relock_count_o); end
    for (int k = 1; k <= 19; k++) begin
      step(1);
      n_checks++; if (mb_reset_o !== logic'(k < 11)) begin n_err++; $display("FAIL glitch_mb k=%0d got=%b exp=%b", k, mb_reset_o, k < 11); end
      n_checks++; if (io_reset_o !== logic'(k < 15)) begin n_err++; $display("FAIL glitch_io k=%0d got=%b exp=%b", k, io_reset_o, k < 15); end
      n_checks++; if (core_reset_o !== logic'(k < 19)) begin n_err++; $display("FAIL glitch_core k=%0d got=%b exp=%b", k, core_reset_o, k < 19); end
      n_checks++; if (ready_o !== logic'(k >= 19)) begin n_err++; $display("FAIL glitch_ready k=%0d got=%b exp=%b", k, ready_o, k >= 19); end
    end
    n_checks++; if (relock_count_o !== 8'd1) begin n_err++; $display("FAIL glitch_count_end got=%0d exp=1", relock_count_o); end
  endtask

  // From DONE: one-cycle lock drop reaches the FSM three edges later.
  task automatic test_lock_loss();
    locked_i = 1'b0;
    step(1);
    locked_i = 1'b1;
    step(1);
    n_checks++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL lockloss_ready_early got=%b exp=1", ready_o); end
    step(1);
    n_checks++; if ({mb_reset_o, io_reset_o, core_reset_o, ready_o} !== 4'b1110) begin n_err++; $display("FAIL lockloss_outs got=%b exp=1110", {mb_reset_o, io_reset_o, core_reset_o, ready_o}); end
    n_checks++; if (relock_count_o !== 8'd2) begin n_err++; $display("FAIL lockloss_count got=%0d exp=2", relock_count_o); end
    for (int k = 1; k <= 17; k++) begin
      step(1);
      n_checks++; if (mb_reset_o !== logic'(k < 9)) begin n_err++; $display("FAIL rerun_mb k=%0d got=%b exp=%b", k, mb_reset_o, k < 9); end
      n_checks++; if (io_reset_o !== logic'(k < 13)) begin n_err++; $display("FAIL rerun_io k=%0d got=%b exp=%b", k, io_reset_o, k < 13); end
      n_checks++; if (core_reset_o !== logic'(k < 17)) begin n_err++; $display("FAIL rerun_core k=%0d got=%b exp=%b", k, core_reset_o, k < 17); end
      n_checks++; if (ready_o !== logic'(k >= 17)) begin n_err++; $display("FAIL rerun_ready k=%0d got=%b exp=%b", k, ready_o, k >= 17); end
    end
  endtask

  task automatic test_sw_gap_core();
    sw_reset_i = 1'b1;
    step(1);
    sw_reset_i = 1'b0;
    step(13);
    n_checks++; if ({mb_reset_o, io_reset_o, core_reset_o, ready_o} !== 4'b0010) begin n_err++; $display("FAIL swgap_in_gap_core got=%b exp=0010", {mb_reset_o, io_reset_o, core_reset_o, ready_o}); end
    sw_reset_i = 1'b1;
    step(1);
    sw_reset_i = 1'b0;
    n_checks++; if ({mb_reset_o, io_reset_o, core_reset_o, ready_o} !== 4'b1110) begin n_err++; $display("FAIL swgap_outs got=%b exp=1110", {mb_reset_o, io_reset_o, core_reset_o, ready_o}); end
    n_checks++; if (relock_count_o !== 8'd2) begin n_err++; $display("FAIL swgap_count got=%0d exp=2", relock_count_o); end
  endtask

  // sw_reset_i lands on the same edge that sees the synchronized lock loss.
  task automatic test_sw_coincident();
    step(1);
    locked_i = 1'b0;
    step(1);
    locked_i = 1'b1;
    step(1);
    sw_reset_i = 1'b1;
    step(1);
    sw_reset_i = 1'b0;
    n_checks++; if ({mb_reset_o, io_reset_o, core_reset_o, ready_o} !== 4'b1110) begin n_err++; $display("FAIL coinc_outs got=%b exp=1110", {mb_reset_o, io_reset_o, core_reset_o, ready_o}); end
    n_checks++; if (relock_count_o !== 8'd3) begin n_err++; $display("FAIL coinc_count got=%0d exp=3", relock_count_o); end
    step(1);
    n_checks++; if (relock_count_o !== 8'd3) begin n_err++; $display("FAIL coinc_count_hold got=%0d exp=3", relock_count_o); end
  endtask

  task automatic lock_loss_events(input int n);
    for (int i = 0; i < n; i++) begin
      locked_i = 1'b0;
      step(1);
      locked_i = 1'b1;
      step(4);
    end
  endtask

  task automatic test_saturation();
    lock_loss_events(251);
    n_checks++; if (relock_count_o !== 8'd254) begin n_err++; $display("FAIL sat_254 got=%0d exp=254", relock_count_o); end
    lock_loss_events(1);
    n_checks++; if (relock_count_o !== 8'd255) begin n_err++; $display("FAIL sat_255 got=%0d exp=255", relock_count_o); end
    lock_loss_events(48);
    n_checks++; if (relock_count_o !== 8'd255) begin n_err++; $display("FAIL sat_hold got=%0d exp=255", relock_count_o); end
  endtask

  // reset_i mid-sequence, coincident with sw_reset_i and lock loss.
  task automatic test_reset_mid();
    reset_i = 1'b1; sw_reset_i = 1'b1; locked_i = 1'b0;
    step(1);
    n_checks++; if (relock_count_o !== 8'd0) begin n_err++; $display("FAIL rstmid_count got=%0d exp=0", relock_count_o); end
    n_checks++; if ({mb_reset_o, io_reset_o, core_reset_o, ready_o} !== 4'b1110) begin n_err++; $display("FAIL rstmid_outs got=%b exp=1110", {mb_reset_o, io_reset_o, core_reset_o, ready_o}); end
    sw_reset_i = 1'b0; locked_i = 1'b1;
    step(2);
    test_powerup();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    test_reset();
    test_powerup();
    test_glitch_stable();
    test_lock_loss();
    test_sw_gap_core();
    test_sw_coincident();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bsg_gateway_reset_seq.md
BSG_GATEWAY_RESET_SEQ -- requirements
Module: bsg_gateway_reset_seq

Interface
REQ-001 The block SHALL have parameter lock_stable_cycles_p, default 1024: number of consecutive cycles of synchronized lock required before the first reset release (legal range ≥1).
REQ-002 The block SHALL have parameter stage_gap_cycles_p, default 64: cycles between successive reset-release stages (legal range ≥1).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk_i, input, 1: the single clock, the gateway microblaze clock; all flops on its rising edge.
REQ-005 Port reset_i, input, 1: synchronous active-high reset.
REQ-006 Port locked_i, input, 1: combined PLL/DCM lock, asynchronous to clk_i.
REQ-007 Port sw_reset_i, input, 1: single-cycle synchronous request to re-run the sequence.
REQ-008 Port mb_reset_o, output, 1: microblaze and tag reset, active-high.
REQ-009 Port io_reset_o, output, 1: io master/serdes domain reset, active-high.
REQ-010 Port core_reset_o, output, 1: core/fast-core domain reset, active-high.
REQ-011 Port ready_o, output, 1: high only when the sequence is complete.
REQ-012 Port relock_count_o, output, 8: count of lock losses after lock acquisition, saturating at 255.

Function
REQ-013 locked_i SHALL pass through a 2-flop synchronizer; only its output, locked_sync, SHALL be used internally.
REQ-014 The FSM SHALL have states WAIT_LOCK, STABLE, GAP_IO, GAP_CORE and DONE, plus one down/up counter sized for max(lock_stable_cycles_p, stage_gap_cycles_p).
REQ-015 In WAIT_LOCK, the FSM SHALL go to STABLE when locked_sync=1, with the counter cleared; otherwise it SHALL stay in WAIT_LOCK.
REQ-016 STABLE SHALL last exactly lock_stable_cycles_p cycles and then go to GAP_IO.
REQ-017 GAP_IO SHALL last exactly stage_gap_cycles_p cycles and then go to GAP_CORE.
REQ-018 GAP_CORE SHALL last exactly stage_gap_cycles_p cycles and then go to DONE.
REQ-019 DONE SHALL hold until lock loss, sw_reset_i or reset_i.
REQ-020 Outputs SHALL be registered Moore decodes of the state, updating in the same cycle as the state register.
REQ-021 mb_reset_o SHALL be 0 only in GAP_IO, GAP_CORE and DONE.
REQ-022 io_reset_o SHALL be 0 only in GAP_CORE and DONE.
REQ-023 core_reset_o SHALL be 0 only in DONE.
REQ-024 ready_o SHALL be 1 only in DONE.
REQ-025 locked_sync=0 in STABLE, GAP_IO, GAP_CORE or DONE SHALL send the FSM to WAIT_LOCK on the next edge and assert all three resets in that same cycle.
REQ-026 A lock loss under REQ-025 SHALL increment relock_count_o by 1, holding at 255 once saturated.
REQ-027 sw_reset_i=1 in any state SHALL send the FSM to WAIT_LOCK on the next edge and SHALL NOT increment relock_count_o.
REQ-028 Simultaneous sw_reset_i=1 and lock loss SHALL increment relock_count_o exactly once.
REQ-029 A locked_sync glitch in WAIT_LOCK SHALL have no effect beyond entering STABLE. A drop in STABLE SHALL return the FSM to WAIT_LOCK and count as a lock loss.
REQ-030 No reset output SHALL deassert out of order (mb, then io, then core). All outputs SHALL be glitch-free, driven directly from flops.

Reset
REQ-031 While reset_i=1 the block SHALL hold: state=WAIT_LOCK, counter=0, synchronizer flops=0, relock_count_o=0, mb_reset_o=io_reset_o=core_reset_o=1, ready_o=0.
REQ-032 reset_i SHALL have priority over sw_reset_i and lock loss.
REQ-033 reset_i asserted mid-sequence SHALL restart the sequence from WAIT_LOCK with relock_count_o cleared.

Structure
REQ-034 The state enum and the relock counter width (8) SHALL live in bsg_gateway_pkg.
REQ-035 The synchronizer SHALL be a separate sub-module, bsg_gateway_sync_2.
REQ-036 All other logic SHALL be in this module.
REQ-037 Neither parameter SHALL be overridden with 0; an elaboration-time assertion SHALL flag 0.

Verification (lock_stable_cycles_p=8, stage_gap_cycles_p=4; cycle 0 = first edge with reset_i=0; locked_i=1 throughout unless stated)
REQ-038 Power-up: STABLE entered at cycle 3; mb_reset_o falls at cycle 11; io_reset_o falls at cycle 15; core_reset_o falls and ready_o rises at cycle 19; relock_count_o=0.
REQ-039 Lock loss in DONE: drop locked_i for 1 cycle -> all resets=1 and ready_o=0 two to three cycles later; relock_count_o=1; the full sequence reruns with the same 8/4/4 spacing.
REQ-040 Glitch in STABLE: locked_i low for 3 cycles during STABLE -> mb_reset_o never falls before 8 full stable cycles after the synchronized recovery; relock_count_o=1.
REQ-041 sw_reset_i: pulse in GAP_CORE -> all resets=1 next cycle; relock_count_o unchanged. Pulse coincident with synchronized lock loss -> count +1 only.
REQ-042 Saturation: 300 lock-loss events -> relock_count_o=255 with no wrap. reset_i=1 then clears it to 0 and restarts the sequence from WAIT_LOCK.
